// File: rtl/uart_pkt_parser.sv
// Packet parser behind the UART receiver: finds the AA 55 header, checks the length and
// checksum, buffers the payload and releases it as a ready/valid stream once the frame is good.
module uart_pkt_parser #(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] cmd,
    output logic [7:0] pld_data,
    output logic       pld_valid,
    input  logic       pld_ready,
    output logic       pld_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       overrun
);

    // state | meaning
    // IDLE  | hunting for 0xAA
    // HDR2  | expecting 0x55 (0xAA keeps resyncing)
    // LEN   | length byte
    // CMD   | command byte
    // PLD   | payload bytes into the buffer
    // CHK   | checksum byte
    // DRAIN | streaming the buffered payload out
    typedef enum logic [2:0] {
        S_IDLE, S_HDR2, S_LEN, S_CMD, S_PLD, S_CHK, S_DRAIN
    } state_t;

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] IDX0      = '0;

    state_t           state;
    logic [7:0]       len;
    logic [7:0]       acc;
    logic [7:0]       cmd_sh;
    logic [7:0]       idx;
    logic [7:0]       rd;
    logic [7:0]       rd_nxt;
    logic [7:0]       len_m1;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             buf_we;
    logic [7:0]       buf_mem [MAX_LEN];

    assign tmo_hit = (tmo_cnt == '0);
    assign buf_we  = (state == S_PLD) && rx_valid && !tmo_hit;
    assign rd_nxt  = rd + 8'd1;
    assign len_m1  = len - 8'd1;

    // Payload storage carries no reset; its contents only matter between PLD and DRAIN.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[idx[IDX_W-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len       <= '0;
            acc       <= '0;
            cmd_sh    <= '0;
            idx       <= '0;
            rd        <= '0;
            tmo_cnt   <= TMO_LOAD;
            cmd       <= '0;
            pld_data  <= '0;
            pld_valid <= 1'b0;
            pld_last  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
            overrun   <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                S_IDLE: begin
                    tmo_cnt <= TMO_LOAD;
                    if (rx_valid && rx_data == 8'hAA) begin
                        state <= S_HDR2;
                    end
                end
                S_DRAIN: begin
                    tmo_cnt <= TMO_LOAD;
                    overrun <= rx_valid;
                    if (pld_ready) begin
                        if (pld_last) begin
                            pld_valid <= 1'b0;
                            pld_last  <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            rd       <= rd_nxt;
                            pld_data <= buf_mem[rd_nxt[IDX_W-1:0]];
                            pld_last <= (rd_nxt == len_m1);
                        end
                    end
                end
                default: begin
                    // Expiry wins over a byte arriving in the same cycle; that byte is dropped.
                    if (tmo_hit) begin
                        frame_err <= 1'b1;
                        err_code  <= 2'd3;
                        state     <= S_IDLE;
                    end else if (rx_valid) begin
                        tmo_cnt <= TMO_LOAD;
                        case (state)
                            S_HDR2: begin
                                if (rx_data == 8'h55) begin
                                    state <= S_LEN;
                                end else if (rx_data != 8'hAA) begin
                                    state <= S_IDLE;
                                end
                            end
                            S_LEN: begin
                                if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
                                    frame_err <= 1'b1;
                                    err_code  <= 2'd1;
                                    state     <= S_IDLE;
                                end else begin
                                    len   <= rx_data;
                                    acc   <= rx_data;
                                    state <= S_CMD;
                                end
                            end
                            S_CMD: begin
                                cmd_sh <= rx_data;
                                acc    <= acc + rx_data;
                                idx    <= '0;
                                state  <= S_PLD;
                            end
                            S_PLD: begin
                                acc <= acc + rx_data;
                                idx <= idx + 8'd1;
                                if (idx + 8'd1 == len) begin
                                    state <= S_CHK;
                                end
                            end
                            S_CHK: begin
                                if (rx_data == acc) begin
                                    frame_ok  <= 1'b1;
                                    cmd       <= cmd_sh;
                                    rd        <= '0;
                                    pld_data  <= buf_mem[IDX0];
                                    pld_valid <= 1'b1;
                                    pld_last  <= (len == 8'd1);
                                    state     <= S_DRAIN;
                                end else begin
                                    frame_err <= 1'b1;
                                    err_code  <= 2'd2;
                                    state     <= S_IDLE;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser: good frames, checksum/length/timeout errors,
// resync, backpressure, overrun and reset mid-frame.
module tb_uart_pkt_parser;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       pld_ready = 1'b0;
    logic [7:0] cmd;
    logic [7:0] pld_data;
    logic       pld_valid;
    logic       pld_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int n_ok   = 0;
    int n_ovr  = 0;
    int base_ok;
    int base_ovr;
    int q_base = 0;
    logic [8:0] q[$];
    logic [8:0] exp_q[$];

    uart_pkt_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd(cmd), .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
        .pld_last(pld_last), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Record every accepted payload byte as {last, data}, plus pulse counts.
    always @(posedge clk) begin
        if (rst_n) begin
            if (pld_valid && pld_ready) q.push_back({pld_last, pld_data});
            if (frame_ok) n_ok++;
            if (overrun) n_ovr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        int got;
        got = q.size() - q_base;
        check({tag, "_count"}, 32'(got), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            check($sformatf("%s_%0d", tag, i),
                  (i < got) ? 32'(q[q_base + i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
        q_base = q.size();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cmd"}, 32'(cmd), 32'h0);
        check({tag, "_pld_data"}, 32'(pld_data), 32'h0);
        check({tag, "_pld_valid"}, 32'(pld_valid), 32'h0);
        check({tag, "_pld_last"}, 32'(pld_last), 32'h0);
        check({tag, "_frame_ok"}, 32'(frame_ok), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_err_code"}, 32'(err_code), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    // Called at a falling edge; the byte is captured by the next rising edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        pld_ready = 1'b1;
        tick(2);
        check_zero("reset");
        rst_n = 1'b1;
        tick(1);

        // Good frame, results at N+1 after the CHK byte
        send(8'hAA); send(8'h55); send(8'h03); send(8'h10);
        send(8'h01); send(8'h02); send(8'h03); send(8'h19);
        check("good_ok", 32'(frame_ok), 32'h1);
        check("good_cmd", 32'(cmd), 32'h10);
        check("good_valid0", 32'(pld_valid), 32'h1);
        check("good_data0", 32'(pld_data), 32'h01);
        check("good_last0", 32'(pld_last), 32'h0);
        tick(1);
        check("good_ok_once", 32'(frame_ok), 32'h0);
        check("good_data1", 32'(pld_data), 32'h02);
        tick(1);
        check("good_data2", 32'(pld_data), 32'h03);
        check("good_last2", 32'(pld_last), 32'h1);
        tick(1);
        check("good_valid_end", 32'(pld_valid), 32'h0);
        exp_q.push_back(9'h001); exp_q.push_back(9'h002); exp_q.push_back(9'h103);
        check_stream("good");

        // Bad checksum starts in the very cycle after the last handshake
        base_ok = n_ok;
        send(8'hAA); send(8'h55); send(8'h03); send(8'h11);
        send(8'h01); send(8'h02); send(8'h03); send(8'h19);
        check("badchk_err", 32'(frame_err), 32'h1);
        check("badchk_code", 32'(err_code), 32'h2);
        check("badchk_valid", 32'(pld_valid), 32'h0);
        tick(3);
        check("badchk_valid_later", 32'(pld_valid), 32'h0);
        check("badchk_cmd_kept", 32'(cmd), 32'h10);
        check("badchk_no_ok", 32'(n_ok - base_ok), 32'h0);
        check_stream("badchk");

        // Length bounds
        send(8'hAA); send(8'h55); send(8'h00);
        check("len0_err", 32'(frame_err), 32'h1);
        check("len0_code", 32'(err_code), 32'h1);
        tick(1);
        check("len0_err_pulse", 32'(frame_err), 32'h0);
        send(8'hAA); send(8'h55); send(8'h11);
        check("len17_err", 32'(frame_err), 32'h1);
        check("len17_code", 32'(err_code), 32'h1);
        send(8'hAA); send(8'h55); send(8'h10); send(8'h42);
        for (int i = 1; i <= 16; i++) send(8'(i));
        send(8'hDA);
        check("len16_ok", 32'(frame_ok), 32'h1);
        check("len16_cmd", 32'(cmd), 32'h42);
        check("len16_data0", 32'(pld_data), 32'h01);
        tick(16);
        check("len16_valid_end", 32'(pld_valid), 32'h0);
        for (int i = 1; i <= 16; i++) exp_q.push_back({(i == 16), 8'(i)});
        check_stream("len16");

        // Byte after TMO-1 idle cycles is still accepted
        send(8'hAA); send(8'h55); send(8'h02); send(8'h20);
        tick(TMO - 1);
        send(8'h30);
        check("tmo_edge_no_err", 32'(frame_err), 32'h0);
        send(8'h40); send(8'h92);
        check("tmo_edge_ok", 32'(frame_ok), 32'h1);
        check("tmo_edge_cmd", 32'(cmd), 32'h20);
        tick(3);
        exp_q.push_back(9'h030); exp_q.push_back(9'h140);
        check_stream("tmo_edge");

        // TMO idle cycles expire; a byte in the expiry cycle is dropped
        send(8'hAA); send(8'h55); send(8'h02); send(8'h20);
        tick(TMO);
        check("tmo_not_yet", 32'(frame_err), 32'h0);
        send(8'h30);
        check("tmo_err", 32'(frame_err), 32'h1);
        check("tmo_code", 32'(err_code), 32'h3);
        send(8'hAA); send(8'hAA); send(8'h55); send(8'h01);
        send(8'h20); send(8'h7F); send(8'hA0);
        check("resync_ok", 32'(frame_ok), 32'h1);
        check("resync_data", 32'(pld_data), 32'h7F);
        check("resync_last", 32'(pld_last), 32'h1);
        tick(2);
        exp_q.push_back(9'h17F);
        check_stream("resync");

        // Backpressure and overrun
        pld_ready = 1'b0;
        base_ovr = n_ovr;
        send(8'hAA); send(8'h55); send(8'h03); send(8'h10);
        send(8'h01); send(8'h02); send(8'h03); send(8'h19);
        check("bp_valid", 32'(pld_valid), 32'h1);
        check("bp_data0", 32'(pld_data), 32'h01);
        tick(2);
        check("bp_hold_valid", 32'(pld_valid), 32'h1);
        check("bp_hold_data0", 32'(pld_data), 32'h01);
        check("bp_hold_last0", 32'(pld_last), 32'h0);
        pld_ready = 1'b1;
        tick(1);
        check("bp_data1", 32'(pld_data), 32'h02);
        pld_ready = 1'b0;
        tick(1);
        check("bp_hold_data1", 32'(pld_data), 32'h02);
        send(8'hAA);
        check("ovr_pulse", 32'(overrun), 32'h1);
        check("ovr_data_kept", 32'(pld_data), 32'h02);
        check("ovr_valid_kept", 32'(pld_valid), 32'h1);
        pld_ready = 1'b1;
        tick(1);
        check("ovr_pulse_end", 32'(overrun), 32'h0);
        check("bp_data2", 32'(pld_data), 32'h03);
        check("bp_last2", 32'(pld_last), 32'h1);
        tick(1);
        check("bp_valid_end", 32'(pld_valid), 32'h0);
        check("ovr_count", 32'(n_ovr - base_ovr), 32'h1);
        exp_q.push_back(9'h001); exp_q.push_back(9'h002); exp_q.push_back(9'h103);
        check_stream("bp");

        // Reset during PLD, then a clean frame
        send(8'hAA); send(8'h55); send(8'h03); send(8'h10); send(8'h01);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        tick(1);
        rst_n = 1'b1;
        tick(1);
        send(8'hAA); send(8'h55); send(8'h01); send(8'h33); send(8'h44); send(8'h78);
        check("postrst_ok", 32'(frame_ok), 32'h1);
        check("postrst_cmd", 32'(cmd), 32'h33);
        check("postrst_data", 32'(pld_data), 32'h44);
        check("postrst_last", 32'(pld_last), 32'h1);
        tick(1);
        check("postrst_valid_end", 32'(pld_valid), 32'h0);
        exp_q.push_back(9'h144);
        check_stream("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_pkt_parser.md
# uart_pkt_parser

Byte-level packet parser sitting directly downstream of the UART receiver in `top_uart`. It consumes one received byte per `rx_valid` pulse, hunts for the frame header, and checks length and checksum. Payload is buffered internally and released as a ready/valid byte stream only after the frame checks out. Bad, oversized or stalled frames are discarded with a one-cycle error pulse and error code.

## Interface
- `MAX_LEN`, 16: maximum payload bytes per frame, range 1..255; sizes the internal buffer.
- `TIMEOUT_CYC`, 50000: maximum idle clock cycles between bytes inside a frame before the frame is aborted.
- `clk`  input  1  single system clock; all logic on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `rx_data`  input  8  received byte from the UART receiver.
- `rx_valid`  input  1  one-cycle strobe; `rx_data` is valid in this cycle.
- `cmd`  output  8  command byte of the last good frame; updates with `frame_ok`.
- `pld_data`  output  8  payload byte.
- `pld_valid`  output  1  `pld_data` is valid.
- `pld_ready`  input  1  consumer accepts the byte when `pld_valid` and `pld_ready` are both high.
- `pld_last`  output  1  marks the final payload byte, qualified by `pld_valid`.
- `frame_ok`  output  1  one-cycle pulse: the frame passed its checks.
- `frame_err`  output  1  one-cycle pulse: the frame was discarded.
- `err_code`  output  2  1 = bad length, 2 = bad checksum, 3 = timeout; valid with `frame_err` and held until the next error.
- `overrun`  output  1  one-cycle pulse: a byte arrived during DRAIN and was dropped.

## Operation
- **Frame format:** `0xAA`, `0x55`, LEN (1..MAX_LEN), CMD, LEN payload bytes, CHK.
- **Checksum:** CHK = (LEN + CMD + payload bytes) mod 256, accumulated in an 8-bit register with wrap-around.
- **FSM states and transitions:**
  - IDLE: `0xAA` goes to HDR2; any other byte is ignored.
  - HDR2: `0x55` goes to LEN; `0xAA` stays in HDR2 (resync); any other byte goes to IDLE with no error.
  - LEN: LEN = 0 or LEN > MAX_LEN raises error code 1 and goes to IDLE. Otherwise the accumulator is set to LEN and the state goes to CMD.
  - CMD: CMD is latched into a shadow register and added to the accumulator; go to PLD.
  - PLD: each byte is written to `buf[idx]`, idx is incremented, and the byte is added to the accumulator. When idx == LEN, go to CHK.
  - CHK: on a match, pulse `frame_ok`, copy the shadow CMD to `cmd`, and go to DRAIN. On a mismatch, raise error code 2 and go to IDLE.
  - DRAIN: present `buf[rd]` with `pld_valid`. `pld_last` is high when rd == LEN-1. After the last handshake, go to IDLE.
- **Timeout:** a cycle counter runs in HDR2, LEN, CMD, PLD and CHK. It is cleared on every `rx_valid`. On reaching TIMEOUT_CYC it raises error code 3 and the FSM goes to IDLE. The counter is idle in IDLE and DRAIN.
- **Overrun:** `rx_valid` in DRAIN drops the byte and pulses `overrun`. Draining continues unaffected.
- **Errors never produce payload output:** no `pld_valid` and no `cmd` update.
- **Reset:** asserting `rst_n` low at any point, including mid-frame or mid-drain, returns the FSM to IDLE.
  - All outputs go to 0: `cmd`=0x00, `pld_data`=0x00, `pld_valid`=0, `pld_last`=0, `frame_ok`=0, `frame_err`=0, `err_code`=0, `overrun`=0.
  - Buffer contents are don't-care after reset.

## Timing
- All outputs are registered.
- **CHK accepted at cycle N:**
  - `frame_ok` and `cmd` are valid at N+1.
  - The first `pld_valid`, carrying `buf[0]`, is at N+1.
  - `frame_err` is also at N+1 when the check fails.
- **Length or timeout errors:** `frame_err` is asserted the cycle after the offending byte, or the cycle after the counter reaches TIMEOUT_CYC.
- **Drain throughput:** one byte per cycle while `pld_ready` is high. A frame of LEN bytes drains in LEN cycles minimum.
- **Backpressure:** `pld_data`, `pld_valid` and `pld_last` hold stable while `pld_valid` is high and `pld_ready` is low.
- **After the last handshake:** `pld_valid` is 0 in the next cycle, and the FSM is in IDLE and able to accept `0xAA` in that cycle.
- **Timeout boundary:** exactly TIMEOUT_CYC idle cycles trigger the timeout. A byte arriving on cycle TIMEOUT_CYC-1 is accepted normally.
- **Simultaneous events:** `rx_valid` arriving in the same cycle the timeout fires gets the timeout; the byte is dropped.

## Test plan
- **Good frame:** `AA 55 03 10 01 02 03 19`, with `pld_ready`=1.
  - `frame_ok` pulses once and `cmd`=0x10.
  - Payload 01, 02, 03 appears on consecutive cycles, with `pld_last` on 03.
- **Bad checksum:** the same frame with CHK=0x18.
  - `frame_err` pulses with `err_code`=2.
  - `pld_valid` never rises and `cmd` stays at its prior value.
- **Length bounds:** LEN=0x00, then LEN=0x11 (MAX_LEN=16) → `frame_err` with `err_code`=1 in each case.
  - A following frame with LEN=16 and CHK = (0x10 + CMD + sum of payload) mod 256 → `frame_ok`, then 16 payload bytes with `pld_last` on the 16th.
- **Timeout and resync:**
  - Send `AA 55 02 20`, then idle for TIMEOUT_CYC cycles → `err_code`=3.
  - Then send `AA AA 55 01 20 7F A0` → `frame_ok`, single payload 7F with `pld_last`=1.
- **Backpressure and overrun:**
  - Good 3-byte frame with `pld_ready` toggling 0/1 → data held stable while `pld_ready` is low, and the order 01, 02, 03 is preserved.
  - An `rx_valid` injected during drain → `overrun` pulses and the payload is unaffected.
- **Reset mid-frame:** assert `rst_n` low during PLD.
  - All outputs are 0 during reset.
  - After release, a good frame is parsed correctly.
